// File: rtl/riscv_pkg.sv
// Shared definitions for the core front end.
//   XLEN                 datapath / PC width
//   RESET_VECTOR_DEF     default pc loaded on reset
//   TRAP_VECTOR_DEF      default pc loaded when a misalign trap is cleared
//   fetch_state_t        fetch FSM encodings (BOOT=0, RUN=1, TRAP=2)
//   is_misaligned()      true when an instruction address is not word aligned
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-pc priority select: redirect > stall > sequential.
//   i_redirect_valid   take i_redirect_target (only if it is word aligned)
//   i_redirect_target  branch/jump target
//   i_stall            hold the current pc
//   i_pc               current pc
//   i_pc_plus4         sequential next pc from the adder
//   o_next_pc          selected next pc (current pc when the redirect is misaligned)
//   o_advance          the pc moves this cycle (counts as a fetch)
//   o_misalign         redirect requested to a non-word-aligned target
module pc_next_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_target,
  input  logic            i_stall,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_advance,
  output logic            o_misalign
);

  logic w_target_bad;

  assign w_target_bad = is_misaligned(i_redirect_target[1:0]);

  always_comb begin
    o_next_pc  = i_pc;
    o_advance  = 1'b0;
    o_misalign = 1'b0;
    if (i_redirect_valid) begin
      // A redirect overrides stall; a bad target leaves pc alone and raises the trap.
      if (w_target_bad) begin
        o_misalign = 1'b1;
      end else begin
        o_next_pc = i_redirect_target;
        o_advance = 1'b1;
      end
    end else if (!i_stall) begin
      o_next_pc = i_pc_plus4;
      o_advance = 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: BOOT/RUN/TRAP FSM, pc register and fetch counter.
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   stall             hold pc this cycle
//   redirect_valid    take redirect_target as next pc
//   redirect_target   branch/jump target
//   pc_plus4          sequential next pc (external adder: pc + 4)
//   trap_clear        leave TRAP and resume at TRAP_VECTOR
//   pc                current fetch address
//   pc_valid          pc is a real fetch (RUN state only)
//   misalign_trap     sticky misaligned-redirect flag
//   trap_pc           offending redirect target
//   fetch_count       cycles in which pc advanced (wraps mod 2^32)
module pc_fetch_unit #(
  parameter int          XLEN         = riscv_pkg::XLEN,
  parameter logic [31:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR_DEF,
  parameter logic [31:0] TRAP_VECTOR  = riscv_pkg::TRAP_VECTOR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            trap_clear,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign_trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [31:0]     fetch_count
);
  import riscv_pkg::*;

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            r_pc_valid;
  logic            r_misalign;
  logic            w_misalign_next;
  logic [XLEN-1:0] r_trap_pc;
  logic [XLEN-1:0] w_trap_pc_next;
  logic [31:0]     r_fetch_count;
  logic [31:0]     w_fetch_count_next;

  logic [XLEN-1:0] w_mux_pc;
  logic            w_mux_advance;
  logic            w_mux_misalign;

  pc_next_mux #(
    .XLEN (XLEN)
  ) u_next_mux (
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .i_stall           (stall),
    .i_pc              (r_pc),
    .i_pc_plus4        (pc_plus4),
    .o_next_pc         (w_mux_pc),
    .o_advance         (w_mux_advance),
    .o_misalign        (w_mux_misalign)
  );

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_misalign_next    = r_misalign;
    w_trap_pc_next     = r_trap_pc;
    w_fetch_count_next = r_fetch_count;
    case (r_state)
      ST_BOOT: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_mux_misalign) begin
          w_state_next    = ST_TRAP;
          w_misalign_next = 1'b1;
          w_trap_pc_next  = redirect_target;
        end else begin
          w_pc_next = w_mux_pc;
          if (w_mux_advance) begin
            w_fetch_count_next = r_fetch_count + 32'd1;
          end
        end
      end
      ST_TRAP: begin
        if (trap_clear) begin
          w_state_next    = ST_RUN;
          w_pc_next       = TRAP_VECTOR[XLEN-1:0];
          w_misalign_next = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR[XLEN-1:0];
      r_pc_valid    <= 1'b0;
      r_misalign    <= 1'b0;
      r_trap_pc     <= '0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      // Registered alongside the state so it is valid exactly while in RUN.
      r_pc_valid    <= (w_state_next == ST_RUN);
      r_misalign    <= w_misalign_next;
      r_trap_pc     <= w_trap_pc_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  assign pc            = r_pc;
  assign pc_valid      = r_pc_valid;
  assign misalign_trap = r_misalign;
  assign trap_pc       = r_trap_pc;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        trap_clear;
  logic [31:0] pc;
  logic        pc_valid;
  logic        misalign_trap;
  logic [31:0] trap_pc;
  logic [31:0] fetch_count;

  int n_cmp;
  int n_bad;

  exp_t exp_q[$];

  // Reference model state (0=BOOT, 1=RUN, 2=TRAP)
  int          m_state;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_trap;
  logic [31:0] m_trap_pc;
  logic [31:0] m_cnt;

  pc_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_plus4        (pc_plus4),
    .trap_clear      (trap_clear),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .misalign_trap   (misalign_trap),
    .trap_pc         (trap_pc),
    .fetch_count     (fetch_count)
  );

  // Stand-in for the PC+4 adder: val_1 = pc, val_2 = 4.
  assign pc_plus4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_pc      = 32'h0;
    m_valid   = 1'b0;
    m_trap    = 1'b0;
    m_trap_pc = 32'h0;
    m_cnt     = 32'h0;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_val({tag, ".pc"},          pc,                   e.pc);
    check_val({tag, ".pc_valid"},    {31'b0, pc_valid},    {31'b0, e.valid});
    check_val({tag, ".trap"},        {31'b0, misalign_trap}, {31'b0, e.trap});
    check_val({tag, ".trap_pc"},     trap_pc,              e.trap_pc);
    check_val({tag, ".fetch_count"}, fetch_count,          e.cnt);
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare after the edge.
  task automatic step(input string tag, input logic st, input logic rv,
                      input logic [31:0] tgt, input logic tc);
    exp_t e;
    stall           = st;
    redirect_valid  = rv;
    redirect_target = tgt;
    trap_clear      = tc;
    case (m_state)
      0: begin
        m_state = 1;
      end
      1: begin
        if (rv) begin
          if (tgt[1:0] != 2'b00) begin
            m_trap_pc = tgt;
            m_trap    = 1'b1;
            m_state   = 2;
          end else begin
            m_pc  = tgt;
            m_cnt = m_cnt + 32'd1;
          end
        end else if (!st) begin
          m_pc  = m_pc + 32'd4;
          m_cnt = m_cnt + 32'd1;
        end
      end
      default: begin
        if (tc) begin
          m_pc    = 32'h0000_0100;
          m_trap  = 1'b0;
          m_state = 1;
        end
      end
    endcase
    m_valid = (m_state == 1);
    e = '{pc: m_pc, valid: m_valid, trap: m_trap, trap_pc: m_trap_pc, cnt: m_cnt};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_outputs(tag, e);
    $display("step %-10s pc=0x%08h valid=%0b trap=%0b trap_pc=0x%08h cnt=%0d",
             tag, pc, pc_valid, misalign_trap, trap_pc, fetch_count);
  endtask

  initial begin
    exp_t r;
    n_cmp = 0;
    n_bad = 0;
    rst             = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    trap_clear      = 1'b0;
    model_reset();
    r = '{pc: 32'h0, valid: 1'b0, trap: 1'b0, trap_pc: 32'h0, cnt: 32'h0};

    // 1: reset values, BOOT, then sequential run
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", r);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("boot", r);
    step("boot2run", 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("run0.pc", pc, 32'h0);
    step("seq1", 1'b0, 1'b0, 32'h0, 1'b0);
    step("seq2", 1'b0, 1'b0, 32'h0, 1'b0);
    step("seq3", 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("seq3.pc", pc, 32'd12);
    check_val("seq3.cnt", fetch_count, 32'd3);
    step("seq4", 1'b0, 1'b0, 32'h0, 1'b1); // trap_clear ignored in RUN

    // 2: stall at 0x10
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h0, 1'b0);
    check_val("stall.pc", pc, 32'h10);
    step("release", 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("release.pc", pc, 32'h14);

    // 3: redirect beats stall
    step("redir", 1'b1, 1'b1, 32'h200, 1'b0);
    check_val("redir.pc", pc, 32'h200);

    // 4: misaligned redirect -> TRAP, inputs ignored, then clear
    step("misalign", 1'b0, 1'b1, 32'h202, 1'b0);
    check_val("misalign.trap_pc", trap_pc, 32'h202);
    step("trap_ign", 1'b0, 1'b1, 32'h400, 1'b0);
    step("trap_stl", 1'b1, 1'b0, 32'h0, 1'b0);
    step("trap_clr", 1'b0, 1'b0, 32'h0, 1'b1);
    check_val("trap_clr.pc", pc, 32'h100);

    // 5: pc wrap via pc_plus4
    step("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step("wrap", 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("wrap.pc", pc, 32'h0);

    // 6: async reset while in TRAP
    step("trap_again", 1'b0, 1'b1, 32'h0000_0033, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst", r);
    @(posedge clk);
    #1;
    check_outputs("rst_hold", r);
    @(negedge clk);
    rst = 1'b0;
    step("boot2run2", 1'b0, 1'b0, 32'h0, 1'b0);
    step("seq_after", 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("seq_after.pc", pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
